// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state/forward-select types and the forwarding match helper for pipe_ctrl.
package pipe_pkg;
   typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} pctrl_state_t;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
   localparam logic [1:0] RESULT_LOAD = 2'b01;
   // M wins over W; x0 is hardwired zero so it never forwards
   function automatic fwd_sel_t fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                        input logic [4:0] rdw, input logic wm, input logic ww);
      return (wm && rdm != 5'd0 && rdm == rs) ? FWD_M :
             (ww && rdw != 5'd0 && rdw == rs) ? FWD_W : FWD_RF;
   endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational operand forward-select for both E-stage sources.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE
);
   assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
   assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller (post-reset bubble, load-use stall, branch flush,
// data-memory wait) with stall/flush performance counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int         CNT_W          = 32,
   parameter logic [1:0] LOAD_RESULTSRC = RESULT_LOAD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemReqM,
   input  logic             dmem_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   pctrl_state_t state;
   logic mem_busy, mem_stall, active, br, lu;
   assign mem_busy  = MemReqM & ~dmem_ready;
   // the ready cycle in MEM_WAIT already releases the stall
   assign mem_stall = (state == MEM_WAIT && !dmem_ready) || (state == RUN && mem_busy);
   assign active    = (state != INIT) && !mem_stall;
   assign br        = active & PCSrcE;
   assign lu        = active && !PCSrcE && ResultSrcE == LOAD_RESULTSRC && RdE != 5'd0 &&
                      (RdE == Rs1D || RdE == Rs2D);
   assign StallF = mem_stall | lu;
   assign StallD = mem_stall | lu;
   assign StallE = mem_stall;
   assign StallM = mem_stall;
   assign FlushD = (state == INIT) | br;
   assign FlushE = (state == INIT) | br | lu;
   assign FlushW = mem_stall;
   fwd_unit u_fwd (
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state == INIT ? RUN :
                      state == RUN  ? (mem_busy ? MEM_WAIT : RUN) :
                      (dmem_ready ? RUN : MEM_WAIT);
         stall_cnt <= stall_cnt + CNT_W'(StallF);
         flush_cnt <= flush_cnt + CNT_W'(br);
      end
   end
endmodule
